// File: rtl/vga_timing_pkg.sv
// Shared VGA 640x480@60 timing constants and the vertical-region encoding.
// Used by the sync pipeline and its region tracker.
package vga_timing_pkg;

    localparam int VGA_H_ACTIVE = 640;
    localparam int VGA_H_FP     = 16;
    localparam int VGA_H_SYNC   = 96;
    localparam int VGA_H_TOTAL  = 800;
    localparam int VGA_V_ACTIVE = 480;
    localparam int VGA_V_FP     = 10;
    localparam int VGA_V_SYNC   = 2;
    localparam int VGA_V_TOTAL  = 525;

    // Sync pulse bounds; the END values are the first count past the pulse.
    localparam int VGA_HS_START = 656;
    localparam int VGA_HS_END   = 752;
    localparam int VGA_VS_START = 490;
    localparam int VGA_VS_END   = 492;

    typedef enum logic [1:0] {
        REGION_ACTIVE = 2'd0,
        REGION_FRONT  = 2'd1,
        REGION_SYNC   = 2'd2,
        REGION_BACK   = 2'd3
    } v_region_e;

endpackage

// File: rtl/vga_region_fsm.sv
// Tracks which vertical region the incoming line belongs to.
// Only steps at the first pixel of a line; the state itself is the output.
module vga_region_fsm
    import vga_timing_pkg::*;
#(
    parameter int V_ACTIVE = VGA_V_ACTIVE,
    parameter int V_FP     = VGA_V_FP,
    parameter int V_SYNC   = VGA_V_SYNC
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        step,
    input  logic [15:0] v_value,
    output v_region_e   region
);

    localparam logic [15:0] FRONT_AT = 16'(V_ACTIVE);
    localparam logic [15:0] SYNC_AT  = 16'(V_ACTIVE + V_FP);
    localparam logic [15:0] BACK_AT  = 16'(V_ACTIVE + V_FP + V_SYNC);

    v_region_e region_q;
    v_region_e region_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            region_q <= REGION_BACK;
        end else begin
            region_q <= region_d;
        end
    end

    always_comb begin
        region_d = region_q;
        if (step) begin
            case (region_q)
                REGION_ACTIVE: if (v_value == FRONT_AT) region_d = REGION_FRONT;
                REGION_FRONT:  if (v_value == SYNC_AT)  region_d = REGION_SYNC;
                REGION_SYNC:   if (v_value == BACK_AT)  region_d = REGION_BACK;
                REGION_BACK:   if (v_value == 16'd0)    region_d = REGION_ACTIVE;
                default:       region_d = region_q;
            endcase
        end
    end

    assign region = region_q;

endmodule

// File: rtl/vga_sync_pipe.sv
// Two-stage VGA sync decoder: stage 1 captures the external counters, stage 2
// registers the decoded sync/video outputs. Both stages advance on pix_en only.
module vga_sync_pipe
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE = VGA_H_ACTIVE,
    parameter int H_FP     = VGA_H_FP,
    parameter int H_SYNC   = VGA_H_SYNC,
    parameter int H_TOTAL  = VGA_H_TOTAL,
    parameter int V_ACTIVE = VGA_V_ACTIVE,
    parameter int V_FP     = VGA_V_FP,
    parameter int V_SYNC   = VGA_V_SYNC,
    parameter int V_TOTAL  = VGA_V_TOTAL
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pix_en,
    input  logic [15:0] h_count,
    input  logic [15:0] v_count,
    output logic        hsync,
    output logic        vsync,
    output logic        video_on,
    output logic [9:0]  pixel_x,
    output logic [9:0]  pixel_y,
    output logic        line_start,
    output logic        frame_start,
    output logic [1:0]  v_region,
    output logic [15:0] frame_count,
    output logic        sync_err
);

    localparam logic [15:0] H_ACT_L = 16'(H_ACTIVE);
    localparam logic [15:0] HS_LO   = 16'(H_ACTIVE + H_FP);
    localparam logic [15:0] HS_HI   = 16'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [15:0] H_TOT_L = 16'(H_TOTAL);
    localparam logic [15:0] H_LAST  = 16'(H_TOTAL - 1);
    localparam logic [15:0] V_ACT_L = 16'(V_ACTIVE);
    localparam logic [15:0] VS_LO   = 16'(V_ACTIVE + V_FP);
    localparam logic [15:0] VS_HI   = 16'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic [15:0] V_TOT_L = 16'(V_TOTAL);

    // Stage 1
    logic [15:0] h1_q, h1_d;
    logic [15:0] v1_q, v1_d;
    logic        s1_valid_q, s1_valid_d;
    logic        sync_err_q, sync_err_d;

    // Stage 2
    logic        hsync_q, hsync_d;
    logic        vsync_q, vsync_d;
    logic        video_on_q, video_on_d;
    logic [9:0]  pixel_x_q, pixel_x_d;
    logic [9:0]  pixel_y_q, pixel_y_d;
    logic        line_start_q, line_start_d;
    logic        frame_start_q, frame_start_d;
    logic [15:0] frame_count_q, frame_count_d;

    logic        active;
    v_region_e   region;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            h1_q          <= '0;
            v1_q          <= '0;
            s1_valid_q    <= 1'b0;
            sync_err_q    <= 1'b0;
            hsync_q       <= 1'b1;
            vsync_q       <= 1'b1;
            video_on_q    <= 1'b0;
            pixel_x_q     <= '0;
            pixel_y_q     <= '0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
            frame_count_q <= '0;
        end else begin
            h1_q          <= h1_d;
            v1_q          <= v1_d;
            s1_valid_q    <= s1_valid_d;
            sync_err_q    <= sync_err_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            video_on_q    <= video_on_d;
            pixel_x_q     <= pixel_x_d;
            pixel_y_q     <= pixel_y_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
            frame_count_q <= frame_count_d;
        end
    end

    // s1_valid marks that stage 1 holds a real sample, so neither the v-change
    // check nor stage 2 acts on the zeroed post-reset contents.
    always_comb begin
        h1_d       = h1_q;
        v1_d       = v1_q;
        s1_valid_d = s1_valid_q;
        sync_err_d = sync_err_q;
        if (pix_en) begin
            h1_d       = h_count;
            v1_d       = v_count;
            s1_valid_d = 1'b1;
            if ((h_count >= H_TOT_L) || (v_count >= V_TOT_L)) sync_err_d = 1'b1;
            if (s1_valid_q && (v_count != v1_q) && (h1_q != H_LAST)) sync_err_d = 1'b1;
        end
    end

    always_comb begin
        active        = (h1_q < H_ACT_L) && (v1_q < V_ACT_L);
        hsync_d       = hsync_q;
        vsync_d       = vsync_q;
        video_on_d    = video_on_q;
        pixel_x_d     = pixel_x_q;
        pixel_y_d     = pixel_y_q;
        line_start_d  = 1'b0;
        frame_start_d = 1'b0;
        frame_count_d = frame_count_q;
        if (pix_en && s1_valid_q) begin
            hsync_d       = !((h1_q >= HS_LO) && (h1_q <= HS_HI));
            vsync_d       = !((v1_q >= VS_LO) && (v1_q <= VS_HI));
            video_on_d    = active;
            pixel_x_d     = active ? h1_q[9:0] : 10'd0;
            pixel_y_d     = active ? v1_q[9:0] : 10'd0;
            line_start_d  = (h1_q == 16'd0);
            frame_start_d = (h1_q == 16'd0) && (v1_q == 16'd0);
            if (frame_start_d) frame_count_d = frame_count_q + 16'd1;
        end
    end

    vga_region_fsm #(
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC)
    ) u_region (
        .clk     (clk),
        .rst_n   (rst_n),
        .step    (pix_en && (h_count == 16'd0)),
        .v_value (v_count),
        .region  (region)
    );

    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign video_on    = video_on_q;
    assign pixel_x     = pixel_x_q;
    assign pixel_y     = pixel_y_q;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;
    assign v_region    = region;
    assign frame_count = frame_count_q;
    assign sync_err    = sync_err_q;

endmodule

// File: tb/tb_vga_sync_pipe.sv
// Bench for vga_sync_pipe: random and directed counter streams compared each
// clock against a line/frame-level reference model of the timing rules.
module tb_vga_sync_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pix_en;
  logic [15:0] h_count;
  logic [15:0] v_count;
  logic        hsync;
  logic        vsync;
  logic        video_on;
  logic [9:0]  pixel_x;
  logic [9:0]  pixel_y;
  logic        line_start;
  logic        frame_start;
  logic [1:0]  v_region;
  logic [15:0] frame_count;
  logic        sync_err;

  int errors = 0;
  int checks = 0;
  bit chk_all = 1'b1;

  // Reference model state
  logic [31:0] hist[$];
  logic        m_hs, m_vs, m_vo, m_ls, m_fs, m_err;
  logic [9:0]  m_px, m_py;
  logic [1:0]  m_reg;
  logic [15:0] m_fc;

  always #5 clk = ~clk;

  vga_sync_pipe dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pix_en      (pix_en),
    .h_count     (h_count),
    .v_count     (v_count),
    .hsync       (hsync),
    .vsync       (vsync),
    .video_on    (video_on),
    .pixel_x     (pixel_x),
    .pixel_y     (pixel_y),
    .line_start  (line_start),
    .frame_start (frame_start),
    .v_region    (v_region),
    .frame_count (frame_count),
    .sync_err    (sync_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Applies one clock of inputs to the model: outputs show the sample taken one
  // accepted strobe earlier, decoded with the plain timing arithmetic.
  task automatic model_step(input logic r, input logic en, input logic [15:0] h, input logic [15:0] v);
    logic [31:0] p;
    logic [15:0] ph, pv;
    if (!r) begin
      hist.delete();
      m_hs = 1'b1; m_vs = 1'b1; m_vo = 1'b0; m_px = '0; m_py = '0;
      m_ls = 1'b0; m_fs = 1'b0; m_reg = 2'd3; m_fc = '0; m_err = 1'b0;
    end else begin
      m_ls = 1'b0;
      m_fs = 1'b0;
      if (en) begin
        if (hist.size() > 0) begin
          p  = hist[hist.size()-1];
          ph = p[31:16];
          pv = p[15:0];
          m_hs = !(ph >= 16'd656 && ph <= 16'd751);
          m_vs = !(pv >= 16'd490 && pv <= 16'd491);
          m_vo = (ph < 16'd640) && (pv < 16'd480);
          m_px = m_vo ? ph[9:0] : 10'd0;
          m_py = m_vo ? pv[9:0] : 10'd0;
          if (ph == 16'd0) m_ls = 1'b1;
          if (ph == 16'd0 && pv == 16'd0) begin
            m_fs = 1'b1;
            m_fc = m_fc + 16'd1;
          end
          if (v != pv && ph != 16'd799) m_err = 1'b1;
        end
        if (h >= 16'd800 || v >= 16'd525) m_err = 1'b1;
        if (h == 16'd0) begin
          case (m_reg)
            2'd0: if (v == 16'd480) m_reg = 2'd1;
            2'd1: if (v == 16'd490) m_reg = 2'd2;
            2'd2: if (v == 16'd492) m_reg = 2'd3;
            default: if (v == 16'd0) m_reg = 2'd0;
          endcase
        end
        hist.push_back({h, v});
        if (hist.size() > 2) void'(hist.pop_front());
      end
    end
  endtask

  task automatic compare_all();
    check("hsync",       32'(hsync),       32'(m_hs));
    check("vsync",       32'(vsync),       32'(m_vs));
    check("video_on",    32'(video_on),    32'(m_vo));
    check("pixel_x",     32'(pixel_x),     32'(m_px));
    check("pixel_y",     32'(pixel_y),     32'(m_py));
    check("line_start",  32'(line_start),  32'(m_ls));
    check("frame_start", 32'(frame_start), 32'(m_fs));
    check("v_region",    32'(v_region),    32'(m_reg));
    check("frame_count", 32'(frame_count), 32'(m_fc));
    check("sync_err",    32'(sync_err),    32'(m_err));
  endtask

  task automatic tick(input logic r, input logic en, input logic [15:0] h, input logic [15:0] v);
    rst_n   = r;
    pix_en  = en;
    h_count = h;
    v_count = v;
    @(posedge clk);
    model_step(r, en, h, v);
    #1;
    if (chk_all) compare_all();
  endtask

  task automatic idle();
    tick(1'b1, 1'b0, 16'($urandom_range(0, 900)), 16'($urandom_range(0, 600)));
  endtask

  // Legal sparse frames: each line shows h=0, one random h, then h=799.
  task automatic walk_frames(input int n, output int vs_lines);
    vs_lines = 0;
    for (int f = 0; f < n; f++) begin
      for (int v = 0; v < 525; v++) begin
        int hs[3];
        hs[0] = 0;
        hs[1] = $urandom_range(1, 798);
        hs[2] = 799;
        for (int k = 0; k < 3; k++) begin
          if ($urandom_range(0, 3) == 0) idle();
          tick(1'b1, 1'b1, 16'(hs[k]), 16'(v));
          if (line_start && !vsync) vs_lines++;
        end
      end
    end
  endtask

  initial begin
    int hs_low, vo_cnt, vs_lines, guard;
    int hv[11];
    logic [15:0] cur_v;
    hv = '{0, 1, 639, 640, 655, 656, 751, 752, 798, 799, 800};

    // Reset state
    tick(1'b0, 1'b0, 16'd0, 16'd0);
    tick(1'b0, 1'b0, 16'd0, 16'd0);
    check("rst_hsync", 32'(hsync), 1);
    check("rst_region", 32'(v_region), 3);

    // Frame start two strobes after (0,0)
    tick(1'b1, 1'b1, 16'd0, 16'd0);
    check("fs_early", 32'(frame_start), 0);
    idle();
    tick(1'b1, 1'b1, 16'd1, 16'd0);
    check("fs_pulse", 32'(frame_start), 1);
    check("fc_one", 32'(frame_count), 1);
    idle();
    check("fs_one_clk", 32'(frame_start), 0);

    // Last visible pixel, then first blanked column
    tick(1'b1, 1'b1, 16'd639, 16'd479);
    tick(1'b1, 1'b1, 16'd640, 16'd479);
    check("px_639", 32'(pixel_x), 639);
    check("py_479", 32'(pixel_y), 479);
    check("vo_last", 32'(video_on), 1);
    tick(1'b1, 1'b1, 16'd641, 16'd479);
    check("vo_blank", 32'(video_on), 0);
    check("px_blank", 32'(pixel_x), 0);

    // One full line with a strobe every 4th clock
    tick(1'b0, 1'b0, 16'd0, 16'd0);
    hs_low = 0;
    vo_cnt = 0;
    for (int h = 0; h < 800; h++) begin
      for (int k = 0; k < 3; k++) idle();
      tick(1'b1, 1'b1, 16'(h), 16'd10);
      if (!hsync) hs_low++;
      if (video_on) vo_cnt++;
    end
    tick(1'b1, 1'b1, 16'd0, 16'd11);
    if (!hsync) hs_low++;
    if (video_on) vo_cnt++;
    check("hs_low_count", hs_low, 96);
    check("vo_line_count", vo_cnt, 640);

    // One legal sparse frame
    tick(1'b0, 1'b0, 16'd0, 16'd0);
    walk_frames(1, vs_lines);
    tick(1'b1, 1'b1, 16'd0, 16'd0);
    tick(1'b1, 1'b1, 16'd1, 16'd0);
    check("vs_lines", vs_lines, 2);
    check("walk_fc", 32'(frame_count), 2);
    check("walk_err", 32'(sync_err), 0);

    // h out of range: sticky error across frames, cleared by reset
    tick(1'b0, 1'b0, 16'd0, 16'd0);
    tick(1'b1, 1'b1, 16'd800, 16'd0);
    check("err_h800", 32'(sync_err), 1);
    walk_frames(3, vs_lines);
    check("err_sticky", 32'(sync_err), 1);
    tick(1'b0, 1'b0, 16'd0, 16'd0);
    check("err_cleared", 32'(sync_err), 0);

    // First update skips the v-change check; legal wrap; illegal mid-line jump
    tick(1'b1, 1'b1, 16'd798, 16'd100);
    check("err_first", 32'(sync_err), 0);
    tick(1'b1, 1'b1, 16'd799, 16'd100);
    tick(1'b1, 1'b1, 16'd0, 16'd101);
    check("err_wrap_ok", 32'(sync_err), 0);
    tick(1'b1, 1'b1, 16'd299, 16'd101);
    tick(1'b1, 1'b1, 16'd300, 16'd102);
    check("err_vjump", 32'(sync_err), 1);

    // Random mix of boundary and arbitrary values, with rare resets
    cur_v = 16'd0;
    for (int i = 0; i < 2000; i++) begin
      logic [15:0] hh;
      if ($urandom_range(0, 2) == 0) hh = 16'(hv[$urandom_range(0, 10)]);
      else hh = 16'($urandom_range(0, 810));
      if ($urandom_range(0, 9) == 0) cur_v = 16'($urandom_range(0, 530));
      tick(($urandom_range(0, 199) != 0), ($urandom_range(0, 2) != 0), hh, cur_v);
    end

    // Frame counter wrap
    tick(1'b0, 1'b0, 16'd0, 16'd0);
    chk_all = 1'b0;
    guard = 0;
    while (m_fc != 16'hffff && guard < 70000) begin
      tick(1'b1, 1'b1, 16'd0, 16'd0);
      guard++;
    end
    chk_all = 1'b1;
    compare_all();
    check("fc_max", 32'(frame_count), 65535);
    tick(1'b1, 1'b1, 16'd0, 16'd0);
    check("fc_wrap", 32'(frame_count), 0);
    check("fc_wrap_fs", 32'(frame_start), 1);

    // Reset mid-frame
    tick(1'b1, 1'b1, 16'd400, 16'd200);
    tick(1'b1, 1'b1, 16'd401, 16'd200);
    tick(1'b0, 1'b1, 16'd402, 16'd200);
    check("mr_hsync", 32'(hsync), 1);
    check("mr_vsync", 32'(vsync), 1);
    check("mr_video_on", 32'(video_on), 0);
    check("mr_pixel_x", 32'(pixel_x), 0);
    check("mr_pixel_y", 32'(pixel_y), 0);
    check("mr_line_start", 32'(line_start), 0);
    check("mr_frame_start", 32'(frame_start), 0);
    check("mr_v_region", 32'(v_region), 3);
    check("mr_frame_count", 32'(frame_count), 0);
    check("mr_sync_err", 32'(sync_err), 0);
    tick(1'b1, 1'b1, 16'd403, 16'd200);
    tick(1'b1, 1'b1, 16'd404, 16'd200);
    check("mr_no_spurious_fs", 32'(frame_start), 0);
    check("mr_resume_px", 32'(pixel_x), 403);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vga_sync_pipe.md
VGA_SYNC_PIPE -- requirements
Module: vga_sync_pipe

Interface
REQ-001 Parameters (name, default, meaning):
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch
- H_SYNC, 96, hsync width
- H_TOTAL, 800, clocks per line
- V_ACTIVE, 480, visible lines
- V_FP, 10, vertical front porch
- V_SYNC, 2, vsync width
- V_TOTAL, 525, lines per frame
REQ-002 Ports (name, direction, width, meaning):
- clk  in  1  pixel-domain clock
- rst_n  in  1  reset: synchronous, active-low, sampled on posedge clk
- pix_en  in  1  pixel strobe, same signal that advances the horizontal counter
- h_count  in  16  horizontal counter value, 0..799
- v_count  in  16  vertical counter value, 0..524
- hsync  out  1  horizontal sync, active-low
- vsync  out  1  vertical sync, active-low
- video_on  out  1  visible-area flag
- pixel_x  out  10  visible column, 0 when blanked
- pixel_y  out  10  visible row, 0 when blanked
- line_start  out  1  one-clk pulse at start of each line
- frame_start  out  1  one-clk pulse at start of each frame
- v_region  out  2  vertical region: 0 ACTIVE, 1 FRONT, 2 SYNC, 3 BACK
- frame_count  out  16  completed-frame counter
- sync_err  out  1  sticky input-sequence error

Function
REQ-003 Two-stage pipeline. Stage 1 registers h_count/v_count; stage 2 registers the decoded outputs. Both stages advance only on clocks with pix_en=1, giving a latency of 2 pix_en cycles. All outputs hold while pix_en=0.
REQ-004 Sync decode:
- hsync=0 iff H_ACTIVE+H_FP <= h <= H_ACTIVE+H_FP+H_SYNC-1 (656..751).
- vsync=0 iff V_ACTIVE+V_FP <= v <= V_ACTIVE+V_FP+V_SYNC-1 (490..491).
REQ-005 video_on=1 iff h<H_ACTIVE and v<V_ACTIVE. pixel_x=h[9:0] and pixel_y=v[9:0] when video_on=1, else both 0.
REQ-006 line_start pulses high for exactly one clk when stage-2 outputs update with h==0. frame_start pulses when stage-2 outputs update with h==0 and v==0. Both are 0 on every other clk, including clocks with pix_en=0.
REQ-007 v_region FSM state changes only on a stage-1 update with h==0:
- ACTIVE->FRONT at v==480
- FRONT->SYNC at v==490
- SYNC->BACK at v==492
- BACK->ACTIVE at v==0
- Any other v: hold state.
REQ-008 frame_count increments by 1 on each frame_start and wraps 65535->0.
REQ-009 sync_err sets to 1 and stays set until reset on any stage-1 update where any of these holds:
- h_count>=H_TOTAL
- v_count>=V_TOTAL
- v_count differs from the previous stage-1 v while the previous h != H_TOTAL-1
REQ-010 When a set condition for sync_err coincides with pix_en=1, the outputs still decode the out-of-range values per REQ-004/005 without saturation.
REQ-011 The first stage-1 update after reset does not evaluate the v-change check.

Reset
REQ-012 rst_n=0 on a posedge clk takes priority over pix_en and sets:
- hsync=1, vsync=1
- video_on=0, pixel_x=0, pixel_y=0
- line_start=0, frame_start=0
- v_region=BACK
- frame_count=0, sync_err=0
- stage-1 registers=0
REQ-013 Reset asserted mid-frame takes effect on the next clk. Operation resumes from the next input values with no spurious frame_start unless h==0 and v==0.

Structure
REQ-014 Package vga_timing_pkg holds the timing constants (H_/V_ values, decode bounds 656/752/490/492) and the v_region encoding.
REQ-015 The v_region FSM (REQ-007) is sub-module vga_region_fsm. All other logic is inline.

Verification
REQ-016 Full frame, pix_en every 4th clk: hsync low for exactly 96 pix_en updates per line; vsync low on lines 490-491; 307200 video_on updates per frame.
REQ-017 Input (h=0,v=0) -> frame_start high exactly one clk, 2 pix_en cycles later; frame_count 0->1.
REQ-018 Input h=639,v=479 -> pixel_x=639, pixel_y=479, video_on=1. Next input h=640 -> video_on=0, pixel_x=0.
REQ-019 Input h=800 -> sync_err=1 after 1 pix_en update; it stays 1 through 3 normal frames; rst_n=0 for 1 clk clears it.
REQ-020 Input v jumps 100->101 at h=300 -> sync_err=1.
REQ-021 Preload frame_count to 65535 via 65535 frames (or force) -> next frame_start wraps it to 0. rst_n=0 at h=400,v=200 -> all outputs at REQ-012 values next clk.
